// File: rtl/sprite_output_unit_if.sv
// Sprite slot load bus between sprite evaluation and the sprite output unit.
interface sprite_output_unit_if;
    logic       load_EN;
    logic [2:0] load_slot;
    logic [7:0] load_patternLow;
    logic [7:0] load_patternHigh;
    logic [7:0] load_attribute;
    logic [7:0] load_x;
    logic       load_isSprite0;

    modport master (output load_EN, load_slot, load_patternLow, load_patternHigh,
                           load_attribute, load_x, load_isSprite0);
    modport slave  (input  load_EN, load_slot, load_patternLow, load_patternHigh,
                           load_attribute, load_x, load_isSprite0);
endinterface

// File: rtl/sprite_output_unit.sv
// Per-scanline sprite shifters feeding the pixel prioritizer; one 6-bit sprite pixel per pixel clock.
// Optional left-edge clipping is built when SPRITE_LEFT_CLIP_EN is defined.
module sprite_slot (
    input  logic       clock,
    input  logic       reset,
    input  logic       clock_EN,
    input  logic       line_clear,
    input  logic       render,
    input  logic       load_hit,
    input  logic [7:0] pat_lo,
    input  logic [7:0] pat_hi,
    input  logic       hflip,
    input  logic       prio_in,
    input  logic [1:0] pal_in,
    input  logic [7:0] x_in,
    input  logic       s0_in,
    output logic [1:0] pix,
    output logic       active,
    output logic       prio,
    output logic [1:0] pal,
    output logic       is_s0
);
    logic [7:0] shift_lo, shift_hi, x_count;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    // A load always wins over this cycle's clear, shift or countdown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_lo <= '0;
            shift_hi <= '0;
            x_count  <= '0;
            prio     <= 1'b0;
            pal      <= '0;
            is_s0    <= 1'b0;
        end else if (clock_EN) begin
            if (load_hit) begin
                shift_lo <= hflip ? rev8(pat_lo) : pat_lo;
                shift_hi <= hflip ? rev8(pat_hi) : pat_hi;
                x_count  <= x_in;
                prio     <= prio_in;
                pal      <= pal_in;
                is_s0    <= s0_in;
            end else if (line_clear) begin
                shift_lo <= '0;
                shift_hi <= '0;
                x_count  <= '0;
            end else if (render) begin
                if (x_count != 8'd0) begin
                    x_count <= x_count - 8'd1;
                end else begin
                    shift_lo <= {shift_lo[6:0], 1'b0};
                    shift_hi <= {shift_hi[6:0], 1'b0};
                end
            end
        end
    end

    assign active = (x_count == 8'd0);
    assign pix    = {shift_hi[7], shift_lo[7]};
endmodule

module sprite_output_unit #(
    parameter int SLOTS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clock_EN,
    input  logic                lineStart,
    input  logic                renderActive,
`ifdef SPRITE_LEFT_CLIP_EN
    input  logic                showLeftSprites,
`endif
    sprite_output_unit_if.slave load,
    output logic [5:0]          spritePixel
);
    logic [SLOTS-1:0][1:0] pix;
    logic [SLOTS-1:0][1:0] pal;
    logic [SLOTS-1:0]      active, prio, is_s0;
    logic [7:0]            col;
    logic [5:0]            win_pix;
    logic                  found;
    logic                  clip;
    logic                  unused_attr;

    assign unused_attr = ^{load.load_attribute[7], load.load_attribute[4:2]};

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        localparam logic [2:0] IDX = 3'(i);
        sprite_slot u_slot (
            .clock      (clock),
            .reset      (reset),
            .clock_EN   (clock_EN),
            .line_clear (lineStart),
            .render     (renderActive),
            .load_hit   (load.load_EN && (load.load_slot == IDX)),
            .pat_lo     (load.load_patternLow),
            .pat_hi     (load.load_patternHigh),
            .hflip      (load.load_attribute[6]),
            .prio_in    (load.load_attribute[5]),
            .pal_in     (load.load_attribute[1:0]),
            .x_in       (load.load_x),
            .s0_in      (load.load_isSprite0),
            .pix        (pix[i]),
            .active     (active[i]),
            .prio       (prio[i]),
            .pal        (pal[i]),
            .is_s0      (is_s0[i])
        );
    end

    // Lowest-index active slot with an opaque leading bit wins.
    always_comb begin
        win_pix = '0;
        found   = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!found && active[i] && (pix[i] != 2'b00)) begin
                found   = 1'b1;
                win_pix = {is_s0[i], prio[i], pal[i], pix[i]};
            end
        end
    end

`ifdef SPRITE_LEFT_CLIP_EN
    assign clip = !showLeftSprites && (col < 8'd8);
`else
    assign clip = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spritePixel <= '0;
            col         <= '0;
        end else if (clock_EN) begin
            spritePixel <= (renderActive && !clip) ? win_pix : 6'd0;
            if (lineStart)
                col <= '0;
            else if (renderActive && (col != 8'hFF))
                col <= col + 8'd1;
        end
    end
endmodule

// File: tb/tb_sprite_output_unit.sv
// Scoreboard bench for sprite_output_unit: column-based reference model, randomized lines.
module tb_sprite_output_unit;
    logic       clock = 1'b0;
    logic       reset, clock_EN, lineStart, renderActive;
`ifdef SPRITE_LEFT_CLIP_EN
    logic       showLeftSprites;
`endif
    logic [5:0] spritePixel;

    sprite_output_unit_if ld_if();

    sprite_output_unit #(.SLOTS(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .clock_EN        (clock_EN),
        .lineStart       (lineStart),
        .renderActive    (renderActive),
`ifdef SPRITE_LEFT_CLIP_EN
        .showLeftSprites (showLeftSprites),
`endif
        .load            (ld_if),
        .spritePixel     (spritePixel)
    );

    always #5 clock = ~clock;

    // Reference model: sprites as column windows, bit 7 = leftmost pixel.
    bit         m_valid[8];
    logic [7:0] m_lo[8], m_hi[8];
    int         m_x[8];
    logic       m_pri[8], m_s0[8];
    logic [1:0] m_pal[8];
    int         m_col;
    logic [5:0] m_last;
    bit         m_show;

    logic [5:0] q[$];
    int  checks = 0, passed = 0;
    bit  mon_on = 1'b0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s col~%0d: got %b want %b at %0t", name, m_col, act, exp, $time);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    function automatic logic [5:0] mpix(input int c);
        int k;
        logic [1:0] b;
        for (int s = 0; s < 8; s++) begin
            if (m_valid[s] && c >= m_x[s] && c <= m_x[s] + 7) begin
                k = 7 - (c - m_x[s]);
                b = {m_hi[s][k], m_lo[s][k]};
                if (b != 2'b00) return {m_s0[s], m_pri[s], m_pal[s], b};
            end
        end
        return 6'd0;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
    endtask

    task automatic cyc(input logic ls, input logic ra, input logic en, input logic ld,
                       input logic [2:0] slot, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] at, input logic [7:0] x, input logic s0);
        logic [5:0] exp;
        bit clip;
        lineStart    = ls;
        renderActive = ra;
        clock_EN     = en;
        ld_if.load_EN          = ld;
        ld_if.load_slot        = slot;
        ld_if.load_patternLow  = lo;
        ld_if.load_patternHigh = hi;
        ld_if.load_attribute   = at;
        ld_if.load_x           = x;
        ld_if.load_isSprite0   = s0;
`ifdef SPRITE_LEFT_CLIP_EN
        showLeftSprites = m_show;
        clip = !m_show && m_col < 8;
`else
        clip = 1'b0;
`endif
        if (!en) begin
            exp = m_last;
        end else begin
            exp = (ra && !clip) ? mpix(m_col) : 6'd0;
            if (ra && m_col < 255) m_col++;
            if (ls) begin
                m_col = 0;
                model_clear();
            end
            if (ld) begin
                m_valid[slot] = 1'b1;
                m_lo[slot]  = at[6] ? rev8(lo) : lo;
                m_hi[slot]  = at[6] ? rev8(hi) : hi;
                m_x[slot]   = int'(x);
                m_pri[slot] = at[5];
                m_pal[slot] = at[1:0];
                m_s0[slot]  = s0;
            end
        end
        m_last = exp;
        @(posedge clock);
        q.push_back(exp);
        #1;
    endtask

    task automatic junk();
        cyc(1'($urandom), 1'($urandom), 1'b0, 1'b1, 3'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic line_start();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic load(input logic [2:0] slot, input logic [7:0] lo, input logic [7:0] hi,
                        input logic [7:0] at, input logic [7:0] x, input logic s0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, slot, lo, hi, at, x, s0);
    endtask

    task automatic render(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) junk();
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    always @(negedge clock) begin
        if (mon_on && q.size() > 0) check("pixel", spritePixel, q.pop_front());
    end

    initial begin
        reset = 1'b1; clock_EN = 1'b0; lineStart = 1'b0; renderActive = 1'b0;
        ld_if.load_EN = 1'b0; ld_if.load_slot = '0; ld_if.load_patternLow = '0;
        ld_if.load_patternHigh = '0; ld_if.load_attribute = '0; ld_if.load_x = '0;
        ld_if.load_isSprite0 = 1'b0;
        m_show = 1'b1;
`ifdef SPRITE_LEFT_CLIP_EN
        showLeftSprites = 1'b1;
`endif
        model_clear();
        m_col = 0; m_last = 6'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_pixel", spritePixel, 6'd0);
        reset = 1'b0;
        mon_on = 1'b1;

        // single sprite-0 pixel at column 5 -> 6'b10_1101
        line_start(); load(3'd0, 8'h80, 8'h00, 8'h03, 8'd5, 1'b1); render(256); idle(2);
        // horizontal flip puts bit 0 at column 0
        line_start(); load(3'd0, 8'h01, 8'h00, 8'h40, 8'd0, 1'b0); render(20); idle(1);
        // overlap: slot 0 over slot 3 where slot 0 is opaque
        line_start(); load(3'd0, 8'hF0, 8'h00, 8'h01, 8'd10, 1'b0);
        load(3'd3, 8'h00, 8'hFF, 8'h22, 8'd8, 1'b0); render(24); idle(1);
        // transparent higher-priority slot, then an empty line
        line_start(); load(3'd0, 8'h00, 8'h00, 8'h03, 8'd20, 1'b0);
        load(3'd1, 8'hFF, 8'h00, 8'h01, 8'd20, 1'b0); render(40); idle(1);
        line_start(); render(256); idle(1);
        // load coinciding with lineStart survives
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'hAA, 8'h55, 8'h02, 8'd3, 1'b0);
        render(16); idle(1);
        // reset in the middle of a sprite
        line_start(); load(3'd0, 8'hFF, 8'hFF, 8'h03, 8'd3, 1'b1); render(6);
        reset = 1'b1;
        q.delete();
        #1;
        check("reset_async", spritePixel, 6'd0);
        model_clear(); m_col = 0; m_last = 6'd0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        render(20); line_start(); render(12); idle(1);
`ifdef SPRITE_LEFT_CLIP_EN
        m_show = 1'b0;
        line_start(); load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd4, 1'b0); render(16); idle(1);
        m_show = 1'b1;
        line_start(); load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd4, 1'b0); render(16); idle(1);
`endif
        // randomized lines
        for (int l = 0; l < 12; l++) begin
            m_show = 1'($urandom);
            line_start();
            for (int n = $urandom_range(0, 10); n > 0; n--)
                load(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 1'($urandom));
            render(256);
            idle(2);
        end
        @(negedge clock);
        #1;
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sprite_output_unit.md
# sprite_output_unit

Per-scanline sprite rendering stage that sits directly upstream of the pixel prioritizer. It holds the up-to-8 sprites selected for the current line, counts each one down to its X position, and shifts out pattern bits. Each enabled pixel clock it emits one 6-bit sprite pixel (sprite-0 flag, priority, palette, pattern) for the prioritizer to merge with the background.

## Interface
Parameters:
- SLOTS, 8, number of sprite slots; slot 0 has the highest priority.

Ports:
- clock in 1: system clock.
- reset in 1: asynchronous, active-high; clears all state.
- clock_EN in 1: pixel-rate enable. All state changes except reset are qualified by it.
- lineStart in 1: clears all slots to transparent and sets the column counter to 0.
- renderActive in 1: high during the 256 visible pixels of a line.
- load_EN in 1: writes one slot.
- load_slot in 3: slot index to write.
- load_patternLow in 8: pattern plane 0 for the slot.
- load_patternHigh in 8: pattern plane 1 for the slot.
- load_attribute in 8: OAM attribute byte. [7] vertical flip is unused here; [6] horizontal flip; [5] priority (1 = behind background); [1:0] palette.
- load_x in 8: sprite X position.
- load_isSprite0 in 1: the slot holds OAM entry 0.
- showLeftSprites in 1: present only with SPRITE_LEFT_CLIP_EN.
- spritePixel out 6: registered. [5] sprite-0 flag, [4] priority, [3:2] palette, [1:0] pattern.

## Operation
- Each slot holds: shiftLow[7:0], shiftHigh[7:0], xCount[7:0], priority, palette[1:0], isSprite0.
- Load (clock_EN && load_EN):
  - Writes the addressed slot.
  - If attribute[6]=1, the pattern bytes are bit-reversed on load, so bit 7 is always the leftmost pixel.
- lineStart (clock_EN):
  - All slots are cleared to shiftLow = shiftHigh = 0 and xCount = 0, which makes them transparent.
  - The column counter is set to 0.
  - A load in the same cycle wins for its slot. The other slots are still cleared.
- Render cycle (clock_EN && renderActive):
  - A slot is active when its xCount == 0.
  - The winning slot is the lowest-index active slot with {shiftHigh[7], shiftLow[7]} != 0.
  - With a winner, spritePixel <= {winner.isSprite0, winner.priority, winner.palette, shiftHigh[7], shiftLow[7]}. With no winner, spritePixel <= 6'b0.
  - Every slot then updates: if xCount != 0, xCount decrements; otherwise both shift registers shift left and fill with 0.
  - The column counter increments and saturates at 255.
  - A load to a slot in the same cycle wins over that slot's shift or decrement.
- clock_EN && !renderActive: spritePixel <= 0. Slots and the column counter hold (except for loads and lineStart).
- clock_EN low: all state holds, including spritePixel.
- The sprite-0 flag is reported whenever sprite 0 supplies the opaque winning pixel. Background qualification is done downstream by the prioritizer.

## Timing
- Latency: the pixel for column c appears on spritePixel one enabled clock after the render cycle at column c.
- A sprite with load_x = X outputs its bit-7 pixel at render column X and its bit-0 pixel at column X+7. Pixels past column 255 are never shown.
- Reset values:
  - spritePixel = 0.
  - All shift registers, xCount, attribute fields and isSprite0 = 0.
  - Column counter = 0.
- Reset mid-line: spritePixel is 0 from the reset edge. After reset, sprites remain transparent until they are reloaded.

## Configuration
- SPRITE_LEFT_CLIP_EN defined:
  - The showLeftSprites port exists.
  - When showLeftSprites = 0 and column < 8, the render cycle forces spritePixel <= 0. Shifting and decrementing continue normally.
- SPRITE_LEFT_CLIP_EN undefined:
  - The port is absent.
  - No clipping is applied.

## Test plan
- Reset, lineStart, then a single load: slot 0 with low = 8'h80, high = 8'h00, attribute = 8'h03, x = 5, isSprite0 = 1. Run 256 render cycles. Required: spritePixel = 6'b10_1101 for exactly column 5 only, and 0 at every other column.
- Horizontal flip: low = 8'h01, attribute = 8'h40, x = 0. Required: the opaque pixel appears at column 0, not column 7.
- Overlap: slot 0 (low = 8'hF0, palette 1, x = 10) and slot 3 (high = 8'hFF, palette 2, priority 1, x = 8).
  - Required at columns 8–9: 6'b01_1010.
  - Required at columns 10–13: 6'b00_0101.
  - Required at columns 14–15: 6'b01_1010.
- Transparent higher-priority slot: slot 0 has an all-zero pattern, slot 1 is opaque. Required: slot 1's pixel is shown. Then a lineStart with no loads. Required: spritePixel = 0 across the whole line.
- Same-cycle collisions:
  - Load slot 2 in the same cycle as lineStart. Required: slot 2 retains the loaded data.
  - Assert reset in the middle of a sprite. Required: spritePixel = 0 immediately, and 0 thereafter until the next load.
- With SPRITE_LEFT_CLIP_EN defined: showLeftSprites = 0 and a sprite at x = 4 with pattern 8'hFF. Required: columns 4–7 output 0 and columns 8–11 are opaque. With showLeftSprites = 1, columns 4–11 are all opaque.
